// File: rtl/e_mul_sched.sv
// e_mul_sched: round-robin arbiter that shares one multi-word multiplier
// between NREQ requesters, with operand capture, result return and a
// watchdog that aborts a multiply that never completes.
module e_mul_sched #(
    parameter int unsigned WORDS   = 32,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*WORDS*16-1:0]    req_a,
    input  logic [NREQ*WORDS*16-1:0]    req_b,
    output logic [NREQ-1:0]             grant,
    output logic [NREQ-1:0]             req_done,
    output logic [WORDS*16-1:0]         result,
    output logic                        timeout_err,
    output logic                        busy,
    output logic                        mul_start,
    output logic [WORDS*16-1:0]         mul_a,
    output logic [WORDS*16-1:0]         mul_b,
    input  logic                        mul_done,
    input  logic [WORDS*16-1:0]         mul_product
);

    localparam int unsigned DW   = WORDS * 16;
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW  = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [WDW-1:0]    wdog_q, wdog_d;
    logic [NREQ-1:0]   grant_d;
    logic [NREQ-1:0]   req_done_d;
    logic [DW-1:0]     result_d;
    logic              timeout_err_d;
    logic              busy_d;
    logic              mul_start_d;
    logic [DW-1:0]     mul_a_d;
    logic [DW-1:0]     mul_b_d;

    logic              pick_vld;
    logic [IDXW-1:0]   pick_idx;
    logic [IDXW:0]     cand;

    // First pending requester at or after the rr pointer, wrapping upward
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (!pick_vld && req[cand[IDXW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDXW-1:0];
            end
        end
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        wdog_d        = wdog_q;
        grant_d       = grant;
        req_done_d    = '0;
        result_d      = result;
        timeout_err_d = timeout_err;
        mul_start_d   = 1'b0;
        mul_a_d       = mul_a;
        mul_b_d       = mul_b;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    owner_d     = pick_idx;
                    grant_d     = NREQ'(1) << pick_idx;
                    mul_a_d     = req_a[32'(pick_idx) * DW +: DW];
                    mul_b_d     = req_b[32'(pick_idx) * DW +: DW];
                    mul_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    result_d   = mul_product;
                    req_done_d = NREQ'(1) << owner_q;
                    state_d    = S_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    result_d      = '0;
                    req_done_d    = NREQ'(1) << owner_q;
                    state_d       = S_RESP;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_RESP: begin
                if (owner_q == IDXW'(NREQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = owner_q + IDXW'(1);
                end
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            wdog_q      <= '0;
            grant       <= '0;
            req_done    <= '0;
            result      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            wdog_q      <= wdog_d;
            grant       <= grant_d;
            req_done    <= req_done_d;
            result      <= result_d;
            timeout_err <= timeout_err_d;
            busy        <= busy_d;
            mul_start   <= mul_start_d;
            mul_a       <= mul_a_d;
            mul_b       <= mul_b_d;
        end
    end

endmodule

// File: doc/e_mul_sched.md
Name: e_mul_sched

Overview:
Round-robin scheduler sharing one multi-word multiplier (e_multi, 16-bit limbs, WORDS limbs, little-endian limb order) between NREQ requesters. Candidates are the squaring stage, the final-scale stage and future series-term stages. The scheduler latches the granted requester's operands, issues a one-cycle start pulse to the multiplier, waits for its done, latches the product and returns a one-cycle done pulse to the owner. A watchdog aborts a hung multiply.

Parameters:
WORDS, 32, number of 16-bit limbs per operand and per product
NREQ, 2, number of requesters (2..8)
TIMEOUT, 65535, max cycles in WAIT before abort (1..2^20-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level; held high until that requester's done pulse
req_a  in  NREQ x WORDS x 16  operand A per requester
req_b  in  NREQ x WORDS x 16  operand B per requester
grant  out  NREQ  one-hot owner indication, high from ISSUE through RESP
req_done  out  NREQ  one-cycle pulse to the owner when the result is valid
result  out  WORDS x 16  latched product, valid from the req_done pulse until the next RESP
timeout_err  out  1  sticky flag, set on watchdog abort
busy  out  1  high in any state other than IDLE
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  WORDS x 16  latched operand A
mul_b  out  WORDS x 16  latched operand B
mul_done  in  1  multiplier completion; level or pulse accepted
mul_product  in  WORDS x 16  multiplier output, sampled on mul_done

Behaviour:
- Reset values (async, rst=1): state IDLE, grant=0, req_done=0, mul_start=0, busy=0, timeout_err=0, result=0, mul_a=0, mul_b=0, rr pointer=0, watchdog=0.
- States and transitions:
  - IDLE: if any req bit is set, pick the first set bit starting at the rr pointer and wrapping upward. Latch its req_a/req_b into mul_a/mul_b, set grant one-hot, go to ISSUE. If no req bit is set, stay in IDLE.
  - ISSUE: mul_start=1 for exactly this cycle; clear the watchdog; go to WAIT. mul_done is ignored in ISSUE.
  - WAIT: if mul_done=1, latch mul_product into result and go to RESP. Otherwise increment the watchdog. When the watchdog reaches TIMEOUT-1 with no mul_done, set timeout_err, set result=0, go to RESP.
  - RESP: req_done[owner]=1 for one cycle. Set rr pointer = (owner+1) mod NREQ. Clear grant. Go to IDLE.
- Latency: req rising in IDLE at cycle 0 gives mul_start in cycle 1. If mul_done arrives in cycle k (k>=2), req_done and result are valid in cycle k+1. The next grant decision is made at cycle k+2, so there are at least 3 cycles of overhead per operation.
- Operands are captured only in IDLE. Changes to req_a/req_b after the grant do not affect an operation in flight.
- Requester drops req during ISSUE or WAIT: the operation still completes and req_done still pulses; the requester ignores it.
- A requester that holds req high after its done is served again only after all other pending requesters are served (round-robin fairness). With a single requester, it is served back-to-back.
- mul_done held high as a level: the scheduler consumes only one completion per ISSUE, since mul_done is sampled only in WAIT.
- The multiplier output is passed through unchanged; the scheduler performs no width change, truncation or arithmetic on it.
- timeout_err is cleared only by rst.
- rst mid-operation: immediate return to IDLE with all reset values applied; no req_done is emitted.

Test Plan:
- Single requester: req[0]=1 with A limb0=3, B limb0=5 (other limbs 0), model multiplier done at +4 cycles -> mul_start exactly 1 cycle at cycle 1; req_done[0] at cycle 6; result limb0=15, other limbs 0.
- Contention: req=2'b11 asserted together, both held -> grants in order 0,1,0,1; no requester is served twice in a row while the other is pending.
- Operand isolation: change req_a[0] in the cycle after grant -> mul_a holds the originally latched value; result matches the original operands.
- Timeout: TIMEOUT=8, mul_done never asserted -> RESP after 8 WAIT cycles; req_done pulses; timeout_err=1 and stays set; result=0.
- Reset mid-WAIT: assert rst during WAIT -> all outputs at reset values in the same cycle; no req_done; the next request is served normally after rst is released.
- Level mul_done: hold mul_done=1 permanently -> each operation still issues its own mul_start, and exactly one req_done is produced per grant.
